// File: rtl/mem_access_ctrl_pkg.sv
// mem_access_ctrl_pkg
// Shared constants and types for the MEM-stage request front end of the
// RAM1/UART controller.
//   ACT_BIT / QUEUE_SIZE     : act-token and receive-queue pointer widths
//   UART_DATA_ADDR           : UART data register (forwarded to the controller)
//   UART_STAT_ADDR           : UART status register (answered locally)
//   TIMEOUT_DEF              : WAIT cycles allowed before an access is abandoned
//   state_t                  : request FSM state encoding
//   stat_word()              : builds the UART status word
package mem_access_ctrl_pkg;

  localparam int          ACT_BIT        = 2;
  localparam int          QUEUE_SIZE     = 4;
  localparam logic [15:0] UART_DATA_ADDR = 16'hBF00;
  localparam logic [15:0] UART_STAT_ADDR = 16'hBF01;
  localparam int          TIMEOUT_DEF    = 1023;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // Bit 0 reads as 1 (transmitter always ready), bit 1 flags pending rx data.
  function automatic logic [15:0] stat_word(input logic rx_avail);
    return {14'b0, rx_avail, 1'b1};
  endfunction

endpackage

// File: rtl/mem_access_ctrl_if.sv
// mem_access_ctrl_if
// Bus between the request front end (master) and the RAM1/UART controller
// (slave).
//   mem_rd / mem_wr          : access request, held for the whole access
//   mem_addr / mem_value     : access address and store data
//   mem_act                  : act token; a new value marks a new access
//   uart_work_done / result  : completion flag and read data from controller
//   queue_front / queue_tail : controller receive-queue pointers
interface mem_access_ctrl_if #(
  parameter int ACT_W = mem_access_ctrl_pkg::ACT_BIT,
  parameter int QW    = mem_access_ctrl_pkg::QUEUE_SIZE
);

  logic             mem_rd;
  logic             mem_wr;
  logic [15:0]      mem_addr;
  logic [15:0]      mem_value;
  logic [ACT_W-1:0] mem_act;
  logic             uart_work_done;
  logic [15:0]      result;
  logic [QW-1:0]    queue_front;
  logic [QW-1:0]    queue_tail;

  modport master (
    output mem_rd, mem_wr, mem_addr, mem_value, mem_act,
    input  uart_work_done, result, queue_front, queue_tail
  );

  modport slave (
    input  mem_rd, mem_wr, mem_addr, mem_value, mem_act,
    output uart_work_done, result, queue_front, queue_tail
  );

endinterface

// File: rtl/mem_access_ctrl_watchdog.sv
// access_watchdog
// Counts cycles while enabled and raises expire during the LIMIT-th enabled
// cycle after a clear.
//   clk, rst : clock, asynchronous active-low reset
//   clr      : restart the count (new access issued)
//   en       : count this cycle (access outstanding)
//   expire   : high for the cycle in which the budget is used up
module access_watchdog #(
  parameter int LIMIT = 1023
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int CW = $clog2(LIMIT + 1);

  logic [CW-1:0] count_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_reg <= '0;
    end else if (clr) begin
      count_reg <= '0;
    end else if (en && !expire) begin
      count_reg <= count_reg + 1'b1;
    end
  end

  // Count holds k-1 during the k-th enabled cycle.
  assign expire = en && (count_reg == CW'(LIMIT - 1));

endmodule

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl
// Turns single-cycle MEM-stage loads/stores into the controller's act-token
// handshake, stalls the pipeline until the access completes, serves the UART
// status register locally and abandons accesses that exceed the watchdog.
//   clk, rst              : clock, asynchronous active-low reset
//   req_rd/req_wr         : load/store request (store wins if both set)
//   req_addr/req_wdata    : access address and store data
//   stall                 : freeze pipeline
//   rdata/rdata_valid     : load result and its one-cycle strobe
//   err/err_addr          : sticky timeout flag and first timed-out address
//   bus                   : controller side (mem_*, done, result, queue ptrs)
module mem_access_ctrl #(
  parameter int          ACT_W          = mem_access_ctrl_pkg::ACT_BIT,
  parameter int          QW             = mem_access_ctrl_pkg::QUEUE_SIZE,
  parameter logic [15:0] UART_DATA_ADDR = mem_access_ctrl_pkg::UART_DATA_ADDR,
  parameter logic [15:0] UART_STAT_ADDR = mem_access_ctrl_pkg::UART_STAT_ADDR,
  parameter int          TIMEOUT        = mem_access_ctrl_pkg::TIMEOUT_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_rd,
  input  logic        req_wr,
  input  logic [15:0] req_addr,
  input  logic [15:0] req_wdata,
  output logic        stall,
  output logic [15:0] rdata,
  output logic        rdata_valid,
  output logic        err,
  output logic [15:0] err_addr,
  mem_access_ctrl_if.master bus
);

  import mem_access_ctrl_pkg::*;

  // The data register is an ordinary forwarded address; it only has to be
  // distinct from the locally answered status register.
  if (UART_DATA_ADDR == UART_STAT_ADDR) begin : g_bad_map
    $error("UART data and status registers must differ");
  end

  state_t           state_reg, state_next;
  logic             mem_rd_reg, mem_rd_next;
  logic             mem_wr_reg, mem_wr_next;
  logic [15:0]      mem_addr_reg, mem_addr_next;
  logic [15:0]      mem_value_reg, mem_value_next;
  logic [ACT_W-1:0] mem_act_reg, mem_act_next;
  logic [15:0]      rdata_reg, rdata_next;
  logic             err_reg, err_next;
  logic [15:0]      err_addr_reg, err_addr_next;

  logic          req_any;
  logic          is_stat;
  logic          rx_avail;
  logic [QW-1:0] queue_front;
  logic [QW-1:0] queue_tail;
  logic          wd_clr;
  logic          wd_expire;

  assign queue_front = bus.queue_front;
  assign queue_tail  = bus.queue_tail;
  assign req_any     = req_rd | req_wr;
  assign is_stat     = (req_addr == UART_STAT_ADDR);
  assign rx_avail    = (queue_front != queue_tail);

  access_watchdog #(.LIMIT(TIMEOUT)) u_watchdog (
    .clk    (clk),
    .rst    (rst),
    .clr    (wd_clr),
    .en     (state_reg == ST_WAIT),
    .expire (wd_expire)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= ST_IDLE;
      mem_rd_reg    <= 1'b0;
      mem_wr_reg    <= 1'b0;
      mem_addr_reg  <= '0;
      mem_value_reg <= '0;
      mem_act_reg   <= '0;
      rdata_reg     <= '0;
      err_reg       <= 1'b0;
      err_addr_reg  <= '0;
    end else begin
      state_reg     <= state_next;
      mem_rd_reg    <= mem_rd_next;
      mem_wr_reg    <= mem_wr_next;
      mem_addr_reg  <= mem_addr_next;
      mem_value_reg <= mem_value_next;
      mem_act_reg   <= mem_act_next;
      rdata_reg     <= rdata_next;
      err_reg       <= err_next;
      err_addr_reg  <= err_addr_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    mem_rd_next    = mem_rd_reg;
    mem_wr_next    = mem_wr_reg;
    mem_addr_next  = mem_addr_reg;
    mem_value_next = mem_value_reg;
    mem_act_next   = mem_act_reg;
    rdata_next     = rdata_reg;
    err_next       = err_reg;
    err_addr_next  = err_addr_reg;
    wd_clr         = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        if (req_any) begin
          if (is_stat) begin
            // Status writes are dropped; only reads update rdata.
            if (!req_wr) rdata_next = stat_word(rx_avail);
            state_next = ST_RESP;
          end else begin
            mem_addr_next  = req_addr;
            mem_value_next = req_wdata;
            mem_wr_next    = req_wr;
            mem_rd_next    = ~req_wr;
            mem_act_next   = mem_act_reg + 1'b1;
            wd_clr         = 1'b1;
            state_next     = ST_WAIT;
          end
        end
      end

      ST_WAIT: begin
        // A completion arriving in the expiry cycle still counts as success.
        if (bus.uart_work_done) begin
          if (mem_rd_reg) rdata_next = bus.result;
          mem_rd_next = 1'b0;
          mem_wr_next = 1'b0;
          state_next  = ST_RESP;
        end else if (wd_expire) begin
          err_next = 1'b1;
          if (!err_reg) err_addr_next = mem_addr_reg;
          rdata_next  = 16'hFFFF;
          mem_rd_next = 1'b0;
          mem_wr_next = 1'b0;
          state_next  = ST_RESP;
        end
      end

      ST_RESP: state_next = ST_IDLE;

      default: state_next = ST_IDLE;
    endcase
  end

  // No path from uart_work_done: stall only looks at state and the request.
  assign stall       = req_any & (state_reg != ST_RESP);
  assign rdata_valid = (state_reg == ST_RESP);
  assign rdata       = rdata_reg;
  assign err         = err_reg;
  assign err_addr    = err_addr_reg;

  assign bus.mem_rd    = mem_rd_reg;
  assign bus.mem_wr    = mem_wr_reg;
  assign bus.mem_addr  = mem_addr_reg;
  assign bus.mem_value = mem_value_reg;
  assign bus.mem_act   = mem_act_reg;

endmodule
